// File: rtl/regfile_wb.sv
// regfile_wb: integer register file with a pending-write scoreboard.
//
// It sits after the MEM/WB pipeline register. The writeback triple
// (RegWEn_wi, AddrD_wi, DataD_wi) commits to a 31-entry array (x1..x31).
// x0 is not stored: it always reads as zero, and writes to it are discarded.
// Two combinational read ports serve decode. Each register r also has a
// saturating pending counter pend[r], which counts in-flight writers. Decode
// uses Stall_o to hold on read-after-write hazards.
//
// Optional feature, selected by the macro REGFILE_BYPASS_EN:
//   defined   - write-first forwarding of the writeback data onto the read
//               ports, and a hazard on the last in-flight writer is released
//               in the same cycle as its writeback.
//   undefined - read ports return array contents only. A stall lasts until
//               the cycle after the final writeback edge.
//
// Issue/stall contract: decode may raise Issue_i in any cycle. The
// scoreboard only accepts the issue when Stall_o is low in that same cycle,
// so an issue attempted while stalled is dropped and decode must present it
// again. Writebacks are never back-pressured and always take effect.
module regfile_wb #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int PEND_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              RegWEn_wi,
    input  logic [ADDR_W-1:0] AddrD_wi,
    input  logic [DATA_W-1:0] DataD_wi,
    input  logic [ADDR_W-1:0] AddrA_i,
    input  logic [ADDR_W-1:0] AddrB_i,
    input  logic              UseA_i,
    input  logic              UseB_i,
    input  logic              Issue_i,
    input  logic [ADDR_W-1:0] AddrIss_i,
    input  logic              Flush_i,
    output logic [DATA_W-1:0] DataA_o,
    output logic [DATA_W-1:0] DataB_o,
    output logic              Stall_o,
    output logic              Ovf_o
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    // Storage for x1..x31. Index 0 does not exist.
    logic [DATA_W-1:0] regs [1:NREG-1];
    logic [PEND_W-1:0] pend [1:NREG-1];
    logic              ovf_q;

    // A writeback that really targets a stored register.
    logic              wb_hit;
    // An issue that the scoreboard accepts this cycle.
    logic              issue_ok;
    logic [NREG-1:1]   inc_vec;
    logic [NREG-1:1]   dec_vec;
    logic [PEND_W-1:0] iss_pend;
    logic              ovf_set;

    // Per-port lookups
    logic [PEND_W-1:0] pend_a;
    logic [PEND_W-1:0] pend_b;
    logic              fwd_a;
    logic              fwd_b;
    logic              haz_a;
    logic              haz_b;

    assign wb_hit   = RegWEn_wi && (AddrD_wi != '0);
    assign issue_ok = Issue_i && !Stall_o && (AddrIss_i != '0);

`ifdef REGFILE_BYPASS_EN
    // Forward the writeback onto a read port that addresses the register
    // being written in this cycle.
    assign fwd_a = wb_hit && (AddrD_wi == AddrA_i);
    assign fwd_b = wb_hit && (AddrD_wi == AddrB_i);
`else
    // No forwarding: read ports show array contents only.
    assign fwd_a = 1'b0;
    assign fwd_b = 1'b0;
`endif

    // Pending-count lookup for each read port. x0 is never pending.
    always_comb begin
        pend_a = '0;
        pend_b = '0;
        if (AddrA_i != '0) pend_a = pend[AddrA_i];
        if (AddrB_i != '0) pend_b = pend[AddrB_i];
    end

    // Read port A: zero for x0, forwarded data when bypassing, else the array.
    always_comb begin
        DataA_o = '0;
        if (AddrA_i != '0) begin
            if (fwd_a) DataA_o = DataD_wi;
            else       DataA_o = regs[AddrA_i];
        end
    end

    // Read port B: same selection as port A.
    always_comb begin
        DataB_o = '0;
        if (AddrB_i != '0) begin
            if (fwd_b) DataB_o = DataD_wi;
            else       DataB_o = regs[AddrB_i];
        end
    end

    // Hazard: a register is hazardous while it has any writer in flight.
    // The exception is the last writer whose data is being forwarded now.
    always_comb begin
        haz_a   = (pend_a != '0) && !(fwd_a && (pend_a == PEND_ONE));
        haz_b   = (pend_b != '0) && !(fwd_b && (pend_b == PEND_ONE));
        Stall_o = (UseA_i && haz_a) || (UseB_i && haz_b);
    end

    // Per-register increment/decrement requests for this cycle.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 1; r < NREG; r++) begin
            inc_vec[r] = issue_ok && (AddrIss_i == ADDR_W'(r));
            dec_vec[r] = wb_hit && (AddrD_wi == ADDR_W'(r));
        end
    end

    // Overflow: an accepted issue hits a saturated counter, and no writeback
    // to the same register cancels it.
    always_comb begin
        iss_pend = '0;
        if (AddrIss_i != '0) iss_pend = pend[AddrIss_i];
        ovf_set = issue_ok && (iss_pend == PEND_MAX)
                  && !(wb_hit && (AddrD_wi == AddrIss_i));
    end

    // Register array: commit the writeback. Reset clears it asynchronously.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int r = 1; r < NREG; r++) regs[r] <= '0;
        end else if (wb_hit) begin
            regs[AddrD_wi] <= DataD_wi;
        end
    end

    // Scoreboard counters and sticky overflow. Flush overrides issue and
    // writeback here. The array write above is not affected by flush.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int r = 1; r < NREG; r++) pend[r] <= '0;
            ovf_q <= 1'b0;
        end else if (Flush_i) begin
            for (int r = 1; r < NREG; r++) pend[r] <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    if (pend[r] != PEND_MAX) pend[r] <= pend[r] + PEND_ONE;
                end else if (dec_vec[r] && !inc_vec[r]) begin
                    if (pend[r] != '0) pend[r] <= pend[r] - PEND_ONE;
                end
            end
            if (ovf_set) ovf_q <= 1'b1;
        end
    end

    assign Ovf_o = ovf_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb. A step table checks ordinary reads, writes
// and stalls. Hand-written sequences then cover RAW timing, counter
// saturation and overflow, same-cycle issue with writeback, flush, and
// asynchronous reset.
module tb_regfile_wb;

    logic        clk_i;
    logic        rst_i;
    logic        RegWEn_wi;
    logic [4:0]  AddrD_wi;
    logic [31:0] DataD_wi;
    logic [4:0]  AddrA_i;
    logic [4:0]  AddrB_i;
    logic        UseA_i;
    logic        UseB_i;
    logic        Issue_i;
    logic [4:0]  AddrIss_i;
    logic        Flush_i;
    logic [31:0] DataA_o;
    logic [31:0] DataB_o;
    logic        Stall_o;
    logic        Ovf_o;

    int n_cmp = 0;
    int n_err = 0;

    regfile_wb dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .RegWEn_wi (RegWEn_wi),
        .AddrD_wi  (AddrD_wi),
        .DataD_wi  (DataD_wi),
        .AddrA_i   (AddrA_i),
        .AddrB_i   (AddrB_i),
        .UseA_i    (UseA_i),
        .UseB_i    (UseB_i),
        .Issue_i   (Issue_i),
        .AddrIss_i (AddrIss_i),
        .Flush_i   (Flush_i),
        .DataA_o   (DataA_o),
        .DataB_o   (DataB_o),
        .Stall_o   (Stall_o),
        .Ovf_o     (Ovf_o)
    );

    // Clock: 10 ns period. Edges are at multiples of 5 ns.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        wen;
        logic [4:0]  ad;
        logic [31:0] dd;
        logic [4:0]  aa;
        logic [4:0]  ab;
        logic        ua;
        logic        ub;
        logic        iss;
        logic [4:0]  ai;
        logic        fl;
        logic [31:0] ea;
        logic [31:0] eb;
        logic        es;
    } vec_t;

    function automatic vec_t mk(input logic wen, input logic [4:0] ad,
                                input logic [31:0] dd, input logic [4:0] aa,
                                input logic [4:0] ab, input logic ua,
                                input logic ub, input logic iss,
                                input logic [4:0] ai, input logic fl,
                                input logic [31:0] ea, input logic [31:0] eb,
                                input logic es);
        vec_t t;
        t.wen = wen; t.ad = ad; t.dd = dd; t.aa = aa; t.ab = ab;
        t.ua = ua; t.ub = ub; t.iss = iss; t.ai = ai; t.fl = fl;
        t.ea = ea; t.eb = eb; t.es = es;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the negedge and check the combinational
    // outputs 1 ns later, before the next posedge commits.
    task automatic step(input vec_t t, input string nm);
        @(negedge clk_i);
        RegWEn_wi = t.wen; AddrD_wi = t.ad; DataD_wi = t.dd;
        AddrA_i = t.aa; AddrB_i = t.ab; UseA_i = t.ua; UseB_i = t.ub;
        Issue_i = t.iss; AddrIss_i = t.ai; Flush_i = t.fl;
        #1;
        chk({nm, ".data_a"}, DataA_o, t.ea);
        chk({nm, ".data_b"}, DataB_o, t.eb);
        chk({nm, ".stall"}, {31'b0, Stall_o}, {31'b0, t.es});
    endtask

    vec_t tbl[20];
    logic [31:0] exp_a;
    logic        exp_s;

    initial begin
        rst_i = 1'b0;
        RegWEn_wi = 0; AddrD_wi = 0; DataD_wi = 0; AddrA_i = 5; AddrB_i = 31;
        UseA_i = 0; UseB_i = 0; Issue_i = 0; AddrIss_i = 0; Flush_i = 0;

        // ---- reset state ----
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst.data_a", DataA_o, 32'h0);
        chk("rst.data_b", DataB_o, 32'h0);
        chk("rst.stall", {31'b0, Stall_o}, 32'h0);
        chk("rst.ovf", {31'b0, Ovf_o}, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // ---- table: wen ad dd  aa ab ua ub iss ai fl  ea eb es ----
        tbl[0]  = mk(0, 0, 0,             0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 32'h11111111,  2, 3,  0, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 2, 32'h22222222,  1, 0,  0, 0, 0, 0, 0, 32'h11111111, 0, 0);
        tbl[3]  = mk(1, 31, 32'hFFFF0000, 2, 1,  0, 0, 0, 0, 0, 32'h22222222, 32'h11111111, 0);
        tbl[4]  = mk(1, 0, 32'h00001234,  31, 0, 0, 0, 0, 0, 0, 32'hFFFF0000, 0, 0);
        tbl[5]  = mk(0, 0, 0,             0, 31, 0, 0, 0, 0, 0, 0, 32'hFFFF0000, 0);
        tbl[6]  = mk(1, 1, 32'hCAFEF00D,  2, 31, 0, 0, 0, 0, 0, 32'h22222222, 32'hFFFF0000, 0);
        tbl[7]  = mk(0, 0, 0,             1, 2,  0, 0, 0, 0, 0, 32'hCAFEF00D, 32'h22222222, 0);
        tbl[8]  = mk(0, 0, 0,             0, 0,  0, 0, 1, 10, 0, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0,             10, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        tbl[10] = mk(0, 0, 0,             0, 10, 0, 1, 0, 0, 0, 0, 0, 1);
        tbl[11] = mk(1, 10, 32'h0000000A, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        tbl[12] = mk(0, 0, 0,             10, 0, 1, 0, 0, 0, 0, 32'h0000000A, 0, 0);
        tbl[13] = mk(0, 0, 0,             0, 0,  0, 0, 1, 12, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 0,             12, 0, 1, 0, 1, 13, 0, 0, 0, 1);
        tbl[15] = mk(0, 0, 0,             13, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[16] = mk(1, 12, 32'h00000012, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        tbl[17] = mk(0, 0, 0,             12, 13, 1, 1, 0, 0, 0, 32'h00000012, 0, 0);
        tbl[18] = mk(0, 0, 0,             0, 0,  0, 0, 1, 0, 0, 0, 0, 0);
        tbl[19] = mk(0, 0, 0,             0, 0,  1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(tbl[i], $sformatf("tbl%0d", i));

        // ---- RAW on x3: issue, dependent read, writeback, release ----
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0), "raw.issue");
        step(mk(0, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 1), "raw.dep");
`ifdef REGFILE_BYPASS_EN
        exp_a = 32'h33333333; exp_s = 1'b0;
`else
        exp_a = 32'h0;        exp_s = 1'b1;
`endif
        step(mk(1, 3, 32'h33333333, 3, 0, 1, 0, 0, 0, 0, exp_a, 0, exp_s), "raw.wb");
        step(mk(0, 0, 0, 3, 0, 1, 0, 0, 0, 0, 32'h33333333, 0, 0), "raw.after");

        // ---- write x7, read on port B in the write cycle and after ----
`ifdef REGFILE_BYPASS_EN
        exp_a = 32'hA5A5A5A5;
`else
        exp_a = 32'h0;
`endif
        step(mk(1, 7, 32'hA5A5A5A5, 0, 7, 0, 0, 0, 0, 0, 0, exp_a, 0), "x7.same");
        step(mk(0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 32'hA5A5A5A5, 0), "x7.next");

        // ---- x9 counter: saturate at 3, overflow, drain with writebacks ----
        for (int i = 0; i < 3; i++)
            step(mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0), $sformatf("sat.iss%0d", i));
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0), "sat.iss3");
        chk("sat.ovf_before", {31'b0, Ovf_o}, 32'h0);
        step(mk(0, 0, 0, 9, 0, 1, 0, 0, 0, 0, 0, 0, 1), "sat.full");
        chk("sat.ovf_set", {31'b0, Ovf_o}, 32'h1);
        for (int i = 0; i < 2; i++)
            step(mk(1, 9, 32'h99, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), $sformatf("sat.wb%0d", i));
        step(mk(0, 0, 0, 9, 0, 1, 0, 0, 0, 0, 32'h99, 0, 1), "sat.one_left");
        step(mk(1, 9, 32'h99, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sat.wb2");
        step(mk(0, 0, 0, 9, 0, 1, 0, 0, 0, 0, 32'h99, 0, 0), "sat.drained");
        chk("sat.ovf_sticky", {31'b0, Ovf_o}, 32'h1);

        // ---- x4: issue and writeback in one cycle, then flush ----
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0), "sim.issue");
        step(mk(1, 4, 32'h44, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0), "sim.both");
        step(mk(0, 0, 0, 4, 0, 1, 0, 0, 0, 0, 32'h44, 0, 1), "sim.still1");
        step(mk(1, 4, 32'h4444, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0), "sim.flush");
        step(mk(0, 0, 0, 4, 5, 1, 1, 0, 0, 0, 32'h4444, 0, 0), "sim.cleared");

        // ---- asynchronous reset in the middle of a cycle ----
        step(mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ar.write");
        step(mk(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0), "ar.issue");
        step(mk(0, 0, 0, 5, 6, 0, 1, 0, 0, 0, 32'hDEADBEEF, 0, 1), "ar.pre");
        #2;
        rst_i = 1'b0;
        #1;
        chk("ar.data_a", DataA_o, 32'h0);
        chk("ar.stall", {31'b0, Stall_o}, 32'h0);
        chk("ar.ovf", {31'b0, Ovf_o}, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        step(mk(0, 0, 0, 5, 6, 0, 1, 0, 0, 0, 0, 0, 0), "ar.post");
        chk("ar.ovf_post", {31'b0, Ovf_o}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
